regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb_pkg.sv | 31 +++
 rtl/regfile_sb_if.sv | 44 ++++
 rtl/regfile_sb_rdport.sv | 63 ++++++
 rtl/regfile_sb.sv | 128 ++++++++++++
 tb/tb_regfile_sb.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared constants, read-source encoding and packed-port slice helpers for regfile_sb.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_sb_pkg;

    // Default geometry: 32 x 32-bit registers, two read ports.
    localparam int D_WIDTH_DEF = 32;
    localparam int A_WIDTH_DEF = 5;
    localparam int N_RD_DEF    = 2;
    // Largest supported number of read ports (the smallest is 1).
    localparam int N_RD_MAX    = 4;

    // Selects where a read port takes its data from.
    typedef enum logic [1:0] {
        SRC_MEM  = 2'd0,
        SRC_WP0  = 2'd1,
        SRC_WP1  = 2'd2,
        SRC_ZERO = 2'd3
    } rd_src_e;

    // Low bit of lane k in a bus that packs lanes of width w side by side.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

    // High bit of lane k in the same packing.
    function automatic int slice_hi(input int k, input int w);
        return (k * w) + w - 1;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bundles the write, issue, read and debug signals of the register file.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is sampled or driven unconditionally.
interface regfile_sb_if #(
    parameter int D_WIDTH = regfile_sb_pkg::D_WIDTH_DEF,
    parameter int A_WIDTH = regfile_sb_pkg::A_WIDTH_DEF,
    parameter int N_RD    = regfile_sb_pkg::N_RD_DEF
);
    // Write port 0 (ALU writeback)
    logic                      wen0;
    logic [A_WIDTH-1:0]        waddr0;
    logic [D_WIDTH-1:0]        wdata0;
    // Write port 1 (load writeback)
    logic                      wen1;
    logic [A_WIDTH-1:0]        waddr1;
    logic [D_WIDTH-1:0]        wdata1;
    // Read ports, lane k at [k*width +: width]
    logic [N_RD*A_WIDTH-1:0]   raddr;
    logic [N_RD*D_WIDTH-1:0]   rdata;
    logic [N_RD-1:0]           rbusy;
    // Scoreboard issue
    logic                      issue_en;
    logic [A_WIDTH-1:0]        issue_addr;
    // Debug read and pending count
    logic [A_WIDTH-1:0]        dbg_addr;
    logic [D_WIDTH-1:0]        dbg_data;
    logic [A_WIDTH:0]          busy_cnt;

    // Pipeline side: drives writes, issues and addresses.
    modport master (
        output wen0, waddr0, wdata0,
        output wen1, waddr1, wdata1,
        output raddr, issue_en, issue_addr, dbg_addr,
        input  rdata, rbusy, dbg_data, busy_cnt
    );

    // Register file side.
    modport slave (
        input  wen0, waddr0, wdata0,
        input  wen1, waddr1, wdata1,
        input  raddr, issue_en, issue_addr, dbg_addr,
        output rdata, rbusy, dbg_data, busy_cnt
    );
endinterface

// File: rtl/regfile_sb_rdport.sv
// One read lane: zero-register gating, same-cycle write forwarding and busy masking.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the address every cycle.
module regfile_sb_rdport
    import regfile_sb_pkg::*;
#(
    parameter int D_WIDTH  = D_WIDTH_DEF,
    parameter int A_WIDTH  = A_WIDTH_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic               rst_i,
    input  logic [A_WIDTH-1:0] raddr_i,
    input  logic [D_WIDTH-1:0] mem_dat_i,
    input  logic               busy_i,
    input  logic               wen0_i,
    input  logic [A_WIDTH-1:0] waddr0_i,
    input  logic [D_WIDTH-1:0] wdata0_i,
    input  logic               wen1_i,
    input  logic [A_WIDTH-1:0] waddr1_i,
    input  logic [D_WIDTH-1:0] wdata1_i,
    output logic [D_WIDTH-1:0] rdata_o,
    output logic               rbusy_o
);

    logic    is_zero;
    logic    hit0;
    logic    hit1;
    rd_src_e src;

    // Register 0 reads as zero and never forwards when hardwired.
    assign is_zero = (ZERO_REG != 0) && (raddr_i == '0);
    assign hit0    = (BYPASS != 0) && wen0_i && (waddr0_i == raddr_i) && !is_zero;
    assign hit1    = (BYPASS != 0) && wen1_i && (waddr1_i == raddr_i) && !is_zero;

    // Pick the data source; port 1 outranks port 0 like it does in storage.
    always_comb begin
        src = SRC_MEM;
        if (rst_i || is_zero) begin
            src = SRC_ZERO;
        end else if (hit1) begin
            src = SRC_WP1;
        end else if (hit0) begin
            src = SRC_WP0;
        end
    end

    // Data mux driven by the selected source.
    always_comb begin
        rdata_o = '0;
        case (src)
            SRC_MEM:  rdata_o = mem_dat_i;
            SRC_WP0:  rdata_o = wdata0_i;
            SRC_WP1:  rdata_o = wdata1_i;
            SRC_ZERO: rdata_o = '0;
            default:  rdata_o = '0;
        endcase
    end

    // A forwarded value is already the result, so the consumer need not stall.
    assign rbusy_o = !rst_i && busy_i && !hit0 && !hit1;

endmodule

// File: rtl/regfile_sb.sv
// Two-write, N-read register file with per-register pending (scoreboard) flags and count.
// Latency: reads and busy flags combinational; writes, issues and busy_cnt update on the next clk edge.
// Backpressure: none; writes and issues are accepted every cycle outside reset.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int D_WIDTH  = D_WIDTH_DEF,
    parameter int A_WIDTH  = A_WIDTH_DEF,
    parameter int N_RD     = N_RD_DEF,   // supported range 1..N_RD_MAX
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic       clk,
    input  logic       rst,
    regfile_sb_if.slave bus
);

    localparam int DEPTH = 1 << A_WIDTH;
    localparam int CW    = A_WIDTH + 1;

    logic [D_WIDTH-1:0]           mem_q [DEPTH];
    logic [DEPTH-1:0]             busy_q;
    logic [DEPTH-1:0]             busy_d;
    logic [CW-1:0]                cnt_q;
    logic [CW-1:0]                cnt_d;

    logic                         we0_ok;
    logic                         we1_ok;
    logic                         issue_ok;
    logic                         set_new;
    logic                         clr0;
    logic                         clr1;
    logic [N_RD-1:0][D_WIDTH-1:0] rdata_w;
    logic [N_RD-1:0]              rbusy_w;

    // Writes and issues aimed at a hardwired register 0 are dropped.
    assign we0_ok   = bus.wen0 && !((ZERO_REG != 0) && (bus.waddr0 == '0));
    assign we1_ok   = bus.wen1 && !((ZERO_REG != 0) && (bus.waddr1 == '0));
    assign issue_ok = bus.issue_en && !((ZERO_REG != 0) && (bus.issue_addr == '0));

    // Storage: port 1 is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (we0_ok) begin
                mem_q[bus.waddr0] <= bus.wdata0;
            end
            if (we1_ok) begin
                mem_q[bus.waddr1] <= bus.wdata1;
            end
        end
    end

    // Next busy vector: writebacks clear, then a new issue sets (new producer wins).
    always_comb begin
        busy_d = busy_q;
        if (bus.wen0) begin
            busy_d[bus.waddr0] = 1'b0;
        end
        if (bus.wen1) begin
            busy_d[bus.waddr1] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[bus.issue_addr] = 1'b1;
        end
    end

    // Incremental count: +1 for an idle register becoming busy, -1 for each distinct
    // busy register being cleared and not re-issued on the same edge.
    always_comb begin
        set_new = issue_ok && !busy_q[bus.issue_addr];
        clr0    = bus.wen0 && busy_q[bus.waddr0]
                  && !(issue_ok && (bus.issue_addr == bus.waddr0));
        clr1    = bus.wen1 && busy_q[bus.waddr1]
                  && !(issue_ok && (bus.issue_addr == bus.waddr1))
                  && !(bus.wen0 && (bus.waddr0 == bus.waddr1));
        cnt_d   = cnt_q + CW'(set_new) - CW'(clr0) - CW'(clr1);
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // One read lane per port; each gets its stored word and busy bit pre-indexed.
    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [A_WIDTH-1:0] ra;
        assign ra = bus.raddr[slice_hi(k, A_WIDTH):slice_lo(k, A_WIDTH)];

        regfile_sb_rdport #(
            .D_WIDTH  (D_WIDTH),
            .A_WIDTH  (A_WIDTH),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rdport (
            .rst_i     (rst),
            .raddr_i   (ra),
            .mem_dat_i (mem_q[ra]),
            .busy_i    (busy_q[ra]),
            .wen0_i    (bus.wen0),
            .waddr0_i  (bus.waddr0),
            .wdata0_i  (bus.wdata0),
            .wen1_i    (bus.wen1),
            .waddr1_i  (bus.waddr1),
            .wdata1_i  (bus.wdata1),
            .rdata_o   (rdata_w[k]),
            .rbusy_o   (rbusy_w[k])
        );
    end

    assign bus.rdata    = rdata_w;
    assign bus.rbusy    = rbusy_w;
    assign bus.busy_cnt = cnt_q;

    // Debug read sees storage only, never in-flight write data.
    assign bus.dbg_data = (rst || ((ZERO_REG != 0) && (bus.dbg_addr == '0)))
                          ? '0 : mem_q[bus.dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// Checks regfile_sb (forwarding on and off) against an array/popcount reference model.
// Latency: inputs change 1 ns after each rising edge, outputs sampled mid-cycle.
// Backpressure: none.
module tb_regfile_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_sb_if #(.D_WIDTH(DW), .A_WIDTH(AW), .N_RD(NR)) bus ();
    regfile_sb_if #(.D_WIDTH(DW), .A_WIDTH(AW), .N_RD(NR)) bus_nb ();

    regfile_sb #(.D_WIDTH(DW), .A_WIDTH(AW), .N_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    regfile_sb #(.D_WIDTH(DW), .A_WIDTH(AW), .N_RD(NR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (bus_nb)
    );

    // Second instance sees the same stimulus
    assign bus_nb.wen0       = bus.wen0;
    assign bus_nb.waddr0     = bus.waddr0;
    assign bus_nb.wdata0     = bus.wdata0;
    assign bus_nb.wen1       = bus.wen1;
    assign bus_nb.waddr1     = bus.waddr1;
    assign bus_nb.wdata1     = bus.wdata1;
    assign bus_nb.raddr      = bus.raddr;
    assign bus_nb.issue_en   = bus.issue_en;
    assign bus_nb.issue_addr = bus.issue_addr;
    assign bus_nb.dbg_addr   = bus.dbg_addr;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain register array plus a set of pending registers
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];

    function automatic void m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (rst || a == 0) return '0;
        if (byp && bus.wen1 && bus.waddr1 == a) return bus.wdata1;
        if (byp && bus.wen0 && bus.waddr0 == a) return bus.wdata0;
        return m_mem[a];
    endfunction

    function automatic logic exp_rb(input logic [AW-1:0] a, input bit byp);
        if (rst) return 1'b0;
        if (byp && a != 0 && ((bus.wen0 && bus.waddr0 == a) || (bus.wen1 && bus.waddr1 == a)))
            return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [DW-1:0] exp_dbg(input logic [AW-1:0] a);
        if (rst || a == 0) return '0;
        return m_mem[a];
    endfunction

    // Apply one clock edge's worth of effects to the model
    function automatic void commit();
        if (rst) return;
        if (bus.wen0 && bus.waddr0 != 0) m_mem[bus.waddr0] = bus.wdata0;
        if (bus.wen1 && bus.waddr1 != 0) m_mem[bus.waddr1] = bus.wdata1;
        if (bus.wen0) m_busy[bus.waddr0] = 1'b0;
        if (bus.wen1) m_busy[bus.waddr1] = 1'b0;
        if (bus.issue_en && bus.issue_addr != 0) m_busy[bus.issue_addr] = 1'b1;
    endfunction

    task automatic check_comb();
        logic [AW-1:0] a;
        for (int k = 0; k < NR; k++) begin
            a = bus.raddr[k*AW +: AW];
            check($sformatf("rdata%0d", k),    64'(bus.rdata[k*DW +: DW]),    64'(exp_rd(a, 1'b1)));
            check($sformatf("rbusy%0d", k),    64'(bus.rbusy[k]),             64'(exp_rb(a, 1'b1)));
            check($sformatf("nb_rdata%0d", k), 64'(bus_nb.rdata[k*DW +: DW]), 64'(exp_rd(a, 1'b0)));
            check($sformatf("nb_rbusy%0d", k), 64'(bus_nb.rbusy[k]),          64'(exp_rb(a, 1'b0)));
        end
        check("dbg_data",    64'(bus.dbg_data),    64'(exp_dbg(bus.dbg_addr)));
        check("nb_dbg_data", 64'(bus_nb.dbg_data), 64'(exp_dbg(bus.dbg_addr)));
    endtask

    // Called 1 ns after an edge; returns 1 ns after the next edge
    task automatic step();
        #1;
        check_comb();
        @(posedge clk);
        commit();
        #1;
        check("busy_cnt",    64'(bus.busy_cnt),    64'(m_cnt()));
        check("nb_busy_cnt", 64'(bus_nb.busy_cnt), 64'(m_cnt()));
    endtask

    task automatic set_idle();
        bus.wen0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
        bus.wen1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
        bus.raddr = '0; bus.issue_en = 1'b0; bus.issue_addr = '0; bus.dbg_addr = '0;
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 2) == 0) return AW'($urandom_range(0, 3));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        rst = 1'b1;
        set_idle();
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_comb();
        check("cnt_in_rst", 64'(bus.busy_cnt), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Everything reads zero after reset
        for (int a = 0; a < DEPTH; a++) begin
            bus.dbg_addr = AW'(a);
            #1;
            check("dbg_after_reset", 64'(bus.dbg_data), 64'd0);
        end
        check("cnt_after_reset", 64'(bus.busy_cnt), 64'd0);
        set_idle();
        @(posedge clk);
        #1;

        // Forwarding of a same-cycle write
        bus.wen0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'hDEADBEEF;
        bus.raddr = {5'd0, 5'd5};
        #1;
        check("fwd_same_cycle",   64'(bus.rdata[DW-1:0]),    64'hDEADBEEF);
        check("nofwd_same_cycle", 64'(bus_nb.rdata[DW-1:0]), 64'd0);
        step();
        set_idle();
        bus.raddr = {5'd0, 5'd5};
        #1;
        check("stored_next",    64'(bus.rdata[DW-1:0]),    64'hDEADBEEF);
        check("nb_stored_next", 64'(bus_nb.rdata[DW-1:0]), 64'hDEADBEEF);
        step();

        // Write collision: port 1 wins; register 0 stays zero
        set_idle();
        bus.wen0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h11;
        bus.wen1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h22;
        bus.raddr = {5'd7, 5'd7};
        step();
        set_idle();
        bus.dbg_addr = 5'd7;
        #1;
        check("collision_p1_wins", 64'(bus.dbg_data), 64'h22);
        bus.wen0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hFF;
        bus.raddr = '0;
        #1;
        check("zero_no_fwd", 64'(bus.rdata[DW-1:0]), 64'd0);
        step();
        set_idle();
        #1;
        check("zero_stored", 64'(bus.rdata[DW-1:0]), 64'd0);
        step();

        // Scoreboard set / same-edge set+clear / clear
        bus.issue_en = 1'b1; bus.issue_addr = 5'd3; bus.raddr = {5'd0, 5'd3};
        step();
        set_idle(); bus.raddr = {5'd0, 5'd3};
        #1;
        check("busy3_set", 64'(bus.rbusy[0]), 64'd1);
        check("cnt_one",   64'(bus.busy_cnt), 64'd1);
        bus.issue_en = 1'b1; bus.issue_addr = 5'd3;
        bus.wen1 = 1'b1; bus.waddr1 = 5'd3; bus.wdata1 = 32'h33;
        step();
        set_idle(); bus.raddr = {5'd0, 5'd3};
        #1;
        check("busy3_kept",     64'(bus.rbusy[0]), 64'd1);
        check("cnt_one_kept",   64'(bus.busy_cnt), 64'd1);
        bus.wen0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h44;
        #1;
        check("busy3_fwd_mask", 64'(bus.rbusy[0]),    64'd0);
        check("nb_busy3_shown", 64'(bus_nb.rbusy[0]), 64'd1);
        step();
        set_idle(); bus.raddr = {5'd0, 5'd3};
        #1;
        check("busy3_clear", 64'(bus.rbusy[0]), 64'd0);
        check("cnt_zero",    64'(bus.busy_cnt), 64'd0);
        step();

        // Fill every issuable register, then re-issue and issue register 0
        for (int a = 1; a < DEPTH; a++) begin
            set_idle();
            bus.issue_en = 1'b1; bus.issue_addr = AW'(a);
            step();
        end
        set_idle(); bus.issue_en = 1'b1; bus.issue_addr = 5'd4;
        step();
        check("cnt_full_reissue", 64'(bus.busy_cnt), 64'd31);
        set_idle(); bus.issue_en = 1'b1; bus.issue_addr = 5'd0;
        step();
        check("cnt_issue_zero", 64'(bus.busy_cnt), 64'd31);

        // Clear, build up ten pending registers, then reset mid-cycle
        set_idle();
        rst = 1'b1;
        m_reset();
        step();
        rst = 1'b0;
        step();
        for (int a = 10; a < 20; a++) begin
            set_idle();
            bus.issue_en = 1'b1; bus.issue_addr = AW'(a);
            bus.wen0 = 1'b1; bus.waddr0 = AW'(a + 10); bus.wdata0 = $urandom;
            step();
        end
        check("cnt_ten", 64'(bus.busy_cnt), 64'd10);
        set_idle();
        bus.wen0 = 1'b1; bus.waddr0 = 5'd12; bus.wdata0 = 32'hCAFE0001;
        bus.wen1 = 1'b1; bus.waddr1 = 5'd25; bus.wdata1 = 32'hCAFE0002;
        bus.issue_en = 1'b1; bus.issue_addr = 5'd5;
        bus.raddr = {5'd25, 5'd11};
        bus.dbg_addr = 5'd20;
        #1;
        rst = 1'b1;
        m_reset();
        #1;
        check("rst_rdata", 64'(bus.rdata),    64'd0);
        check("rst_rbusy", 64'(bus.rbusy),    64'd0);
        check("rst_dbg",   64'(bus.dbg_data), 64'd0);
        check("rst_cnt",   64'(bus.busy_cnt), 64'd0);
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        set_idle();
        step();
        for (int a = 0; a < DEPTH; a++) begin
            bus.dbg_addr = AW'(a);
            #1;
            check("dbg_after_midrst", 64'(bus.dbg_data), 64'd0);
        end
        set_idle();
        @(posedge clk);
        #1;

        // Randomized traffic with collisions and occasional resets
        for (int n = 0; n < 1500; n++) begin
            bus.wen0       = ($urandom_range(0, 2) != 0);
            bus.waddr0     = rnd_addr();
            bus.wdata0     = $urandom;
            bus.wen1       = ($urandom_range(0, 2) == 0);
            bus.waddr1     = ($urandom_range(0, 3) == 0) ? bus.waddr0 : rnd_addr();
            bus.wdata1     = $urandom;
            bus.issue_en   = ($urandom_range(0, 1) == 0);
            bus.issue_addr = ($urandom_range(0, 4) == 0) ? bus.waddr0 : rnd_addr();
            for (int k = 0; k < NR; k++) begin
                case ($urandom_range(0, 3))
                    0:       bus.raddr[k*AW +: AW] = bus.waddr0;
                    1:       bus.raddr[k*AW +: AW] = bus.waddr1;
                    default: bus.raddr[k*AW +: AW] = rnd_addr();
                endcase
            end
            bus.dbg_addr = rnd_addr();
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                m_reset();
            end else begin
                rst = 1'b0;
            end
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
